// File: rtl/audio_sample_sink_pkg.sv
// Shared audio definitions: sample type and rate-divider constants for a 30 MHz system clock.
package audio_sample_sink_pkg;

  typedef logic signed [15:0] sample_t;

  localparam int SYS_CLK_HZ = 30_000_000;

  // 30 MHz / 37.8 kHz, rounded to the nearest whole cycle
  localparam int DIV_37K8 = 794;

  // 30 MHz / 44.1 kHz (CD-DA), rounded to the nearest whole cycle
  localparam int DIV_44K1 = 680;

endpackage

// File: rtl/audio_sample_sink_sample_fifo.sv
// Synchronous sample FIFO with extra-MSB pointers and a registered head output.
module sample_fifo
  import audio_sample_sink_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  sample_t                    push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level,
  output sample_t                    head_data
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  sample_t     mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // Pointer update; flush wins over any push or pop in the same cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Sample storage; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // Head register captures the popped sample and holds it until the next pop
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_data <= '0;
    end else if (do_pop) begin
      head_data <= mem[rd_ptr[AW-1:0]];
    end
  end

endmodule

// File: rtl/audio_sample_sink.sv
// Audiostream sink: buffers incoming samples and releases one per rate tick.
module audio_sample_sink
  import audio_sample_sink_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int DIV   = DIV_37K8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       write,
  input  sample_t                    sample,
  output logic                       strobe,
  input  logic                       enable,
  input  logic                       flush,
  input  logic                       clear_flags,
  output sample_t                    sample_out,
  output logic                       sample_valid,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic                       underrun
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int CW = $clog2(DIV);

  logic [CW-1:0] div_cnt;
  logic          tick;
  logic          accept;
  logic          fifo_full;
  logic          fifo_empty;
  logic [LW-1:0] fifo_level;
  logic [LW-1:0] level_next;

  assign tick   = enable && (div_cnt == CW'(DIV - 1));
  assign accept = write && strobe && !fifo_full;
  assign level  = fifo_level;

  sample_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (accept),
    .push_data (sample),
    .pop       (tick),
    .flush     (flush),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level),
    .head_data (sample_out)
  );

  // Rate divider: free-runs 0..DIV-1 while enabled, parked at 0 otherwise
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (!enable || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Occupancy after this edge, used so strobe drops on the edge that fills the FIFO
  always_comb begin
    level_next = fifo_level;
    if (flush) begin
      level_next = '0;
    end else begin
      if (accept)             level_next = level_next + LW'(1);
      if (tick && !fifo_empty) level_next = level_next - LW'(1);
    end
  end

  // Registered ready and per-tick valid pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      strobe       <= 1'b0;
      sample_valid <= 1'b0;
    end else begin
      strobe       <= (level_next < LW'(DEPTH));
      sample_valid <= tick;
    end
  end

  // Sticky error flags; a new event in the same cycle beats clear_flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
      underrun <= 1'b0;
    end else begin
      overflow <= (write && !strobe) || (overflow && !clear_flags);
      underrun <= (tick && fifo_empty) || (underrun && !clear_flags);
    end
  end

endmodule
